int_res_mem_arbiter: RTL

- Arbitrates two requesters for the 4-bank intermediate-results memory (4 x 14336 words, 15-bit words): requester 0 is the inference master FSM, requester 1 is the compute datapath.
- Decodes the flat IntResAddr_t space into bank select and bank offset.
- Sequences double-width (30-bit) accesses as two consecutive single-word bank accesses.
- Returns read data with fixed latency.

---
 rtl/int_res_mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/int_res_mem_arbiter.sv
// rtl/int_res_mem_arbiter.sv - two-requester arbiter for the 4-bank intermediate-results memory
// Decodes flat word addresses, splits double-width accesses into two bank words, fixed read latency.
module int_res_mem_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_SIZE = 14336,
    parameter int N_STO     = 15,
    localparam int BW       = $clog2(NUM_BANKS),
    localparam int AW       = $clog2(BANK_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       req_i,
    input  logic [1:0]                       we_i,
    input  logic [1:0]                       width_i,
    input  logic [15:0]                      addr0_i,
    input  logic [15:0]                      addr1_i,
    input  logic [2*N_STO-1:0]               wdata0_i,
    input  logic [2*N_STO-1:0]               wdata1_i,
    output logic [1:0]                       gnt_o,
    output logic [1:0]                       rvalid_o,
    output logic [2*N_STO-1:0]               rdata_o,
    output logic                             err_o,
    output logic                             busy_o,
    output logic [NUM_BANKS-1:0]             bank_en_o,
    output logic                             bank_we_o,
    output logic [AW-1:0]                    bank_addr_o,
    output logic [N_STO-1:0]                 bank_wdata_o,
    input  logic [NUM_BANKS-1:0][N_STO-1:0]  bank_rdata_i
);

    typedef enum logic [1:0] {IDLE, DW_SECOND, RD_WAIT} state_t;

    localparam logic [16:0] LIMIT = 17'(NUM_BANKS * BANK_SIZE);

    function automatic logic [BW-1:0] bank_of(input logic [16:0] a);
        bank_of = '0;
        for (int i = 1; i < NUM_BANKS; i++)
            if (a >= 17'(i * BANK_SIZE)) bank_of = BW'(i);
    endfunction

    function automatic logic [AW-1:0] off_of(input logic [16:0] a, input logic [BW-1:0] b);
        return AW'(a - 17'(b) * 17'(BANK_SIZE));
    endfunction

    state_t             state;
    logic               last_gnt;
    logic               id_q, we_q, width_q, err_q;
    logic [15:0]        addr_q;
    logic [2*N_STO-1:0] wdata_q;
    logic [N_STO-1:0]   msb_q;
    logic [BW-1:0]      rd_bank_q;
    logic [2*N_STO-1:0] rdata_q;

    logic               any_req, sel, sel_we, sel_w, illegal;
    logic [15:0]        sel_addr;
    logic [2*N_STO-1:0] sel_wdata;
    logic [16:0]        issue_addr;
    logic [BW-1:0]      issue_bank;
    logic [N_STO-1:0]   rd_word;
    logic [2*N_STO-1:0] rd_val;

    always_comb begin
        any_req    = |req_i;
        // both requesting: the one not served last wins
        sel        = (&req_i) ? ~last_gnt : (req_i[1] & ~req_i[0]);
        sel_addr   = sel ? addr1_i : addr0_i;
        sel_wdata  = sel ? wdata1_i : wdata0_i;
        sel_we     = we_i[sel];
        sel_w      = width_i[sel];
        illegal    = ({1'b0, sel_addr} >= LIMIT) || (sel_w && ({1'b0, sel_addr} == LIMIT - 17'd1));
        issue_addr = (state == DW_SECOND) ? ({1'b0, addr_q} + 17'd1) : {1'b0, sel_addr};
        issue_bank = bank_of(issue_addr);
        rd_word    = bank_rdata_i[rd_bank_q];
        rd_val     = err_q   ? '0 :
                     width_q ? {msb_q, rd_word} :
                               {{N_STO{rd_word[N_STO-1]}}, rd_word};

        gnt_o        = '0;
        rvalid_o     = '0;
        rdata_o      = '0;
        err_o        = 1'b0;
        busy_o       = 1'b0;
        bank_en_o    = '0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        if (!rst) begin
            busy_o  = (state != IDLE);
            rdata_o = rdata_q;
            case (state)
                IDLE: if (any_req) begin
                    gnt_o[sel] = 1'b1;
                    err_o      = illegal;
                    if (!illegal) begin
                        bank_en_o[issue_bank] = 1'b1;
                        bank_we_o             = sel_we;
                        bank_addr_o           = off_of(issue_addr, issue_bank);
                        bank_wdata_o          = sel_w ? sel_wdata[2*N_STO-1:N_STO] : sel_wdata[N_STO-1:0];
                    end
                end
                DW_SECOND: begin
                    bank_en_o[issue_bank] = 1'b1;
                    bank_we_o             = we_q;
                    bank_addr_o           = off_of(issue_addr, issue_bank);
                    bank_wdata_o          = wdata_q[N_STO-1:0];
                end
                RD_WAIT: begin
                    rvalid_o[id_q] = 1'b1;
                    rdata_o        = rd_val;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            width_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            msb_q     <= '0;
            rd_bank_q <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    id_q      <= sel;
                    we_q      <= sel_we;
                    width_q   <= sel_w;
                    addr_q    <= sel_addr;
                    wdata_q   <= sel_wdata;
                    last_gnt  <= sel;
                    err_q     <= illegal;
                    rd_bank_q <= issue_bank;
                    if (illegal)
                        state <= sel_we ? IDLE : RD_WAIT;
                    else if (sel_w)
                        state <= DW_SECOND;
                    else if (!sel_we)
                        state <= RD_WAIT;
                end
                DW_SECOND: begin
                    if (!we_q) msb_q <= rd_word;
                    rd_bank_q <= issue_bank;
                    state     <= we_q ? IDLE : RD_WAIT;
                end
                RD_WAIT: begin
                    rdata_q <= rd_val;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
